// File: rtl/vga_fb_scanout.sv
// 8-bit greyscale framebuffer with VGA raster scan-out (counters -> RAM read -> output registers).
// Optional build macro VGA_SCANLINE_EN halves intensity on odd active lines.
module vga_fb_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIXEL_COUNT = H_ACTIVE * V_ACTIVE
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        hs,
    output logic        vs,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        VGA_HB,
    output logic        VGA_VB,
    output logic        VGA_DE
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(PIXEL_COUNT);

    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] rd_addr;
    logic          active;
    logic          hblank;
    logic          vblank;
    logic          hsync_n;
    logic          vsync_n;
    logic          frame_wrap;
    logic          wr_ok;

    logic [7:0]    mem [PIXEL_COUNT];
    logic [7:0]    ram_q;
    logic          act1;
    logic          hs1;
    logic          vs1;
    logic          hb1;
    logic          vb1;
    logic [7:0]    pix;
`ifdef VGA_SCANLINE_EN
    logic          odd1;
`endif

    // Stage 0: raster position and the flags derived from it
    always_comb begin
        hblank     = (h_cnt >= H_ACT_END);
        vblank     = (v_cnt >= V_ACT_END);
        active     = !hblank && !vblank;
        hsync_n    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync_n    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        wr_ok      = cpu_wr && (cpu_addr < 32'(PIXEL_COUNT));
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            rd_addr <= '0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            // Raster-order address walks with the active pixels, so no y*width multiply
            if (frame_wrap)
                rd_addr <= '0;
            else if (active)
                rd_addr <= rd_addr + 1'b1;
        end
    end

    // Writes ignore reset; the read sees pre-write data on a same-address collision
    always_ff @(posedge pclk) begin
        if (wr_ok)
            mem[cpu_addr[AW-1:0]] <= cpu_data;
        ram_q <= mem[rd_addr];
    end

    // Stage 1: flags travel alongside the RAM read
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            act1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            hb1  <= 1'b1;
            vb1  <= 1'b1;
        end else begin
            act1 <= active;
            hs1  <= hsync_n;
            vs1  <= vsync_n;
            hb1  <= hblank;
            vb1  <= vblank;
        end
    end

`ifdef VGA_SCANLINE_EN
    always_ff @(posedge pclk) begin
        if (!reset_n)
            odd1 <= 1'b0;
        else
            odd1 <= v_cnt[0];
    end
`endif

    always_comb begin
        pix = act1 ? ram_q : '0;
`ifdef VGA_SCANLINE_EN
        if (act1 && odd1)
            pix = {1'b0, ram_q[7:1]};
`endif
    end

    // Stage 2: registered pins
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            hs     <= 1'b1;
            vs     <= 1'b1;
            VGA_HB <= 1'b1;
            VGA_VB <= 1'b1;
            VGA_DE <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
        end else begin
            hs     <= hs1;
            vs     <= vs1;
            VGA_HB <= hb1;
            VGA_VB <= vb1;
            VGA_DE <= !hb1 && !vb1;
            r      <= pix;
            g      <= pix;
            b      <= pix;
        end
    end

endmodule
